// File: rtl/mblight_zone_color_writer_if.sv
// Pixel sink (Avalon-ST) and colour-RAM write master (Avalon-MM) bundle.
// The zone writer uses the master view; the stream source and RAM interconnect use the slave view.
interface mblight_zone_color_writer_if #(
    parameter int ADDR_W = 13
);
    logic [23:0]       snk_data;
    logic              snk_valid;
    logic              snk_ready;
    logic              snk_sop;
    logic              snk_eop;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;

    modport master (
        input  snk_data, snk_valid, snk_sop, snk_eop, avm_waitrequest,
        output snk_ready, avm_address, avm_byteenable, avm_chipselect,
        avm_write, avm_writedata
    );

    modport slave (
        output snk_data, snk_valid, snk_sop, snk_eop, avm_waitrequest,
        input  snk_ready, avm_address, avm_byteenable, avm_chipselect,
        avm_write, avm_writedata
    );
endinterface

// File: rtl/mblight_zone_color_writer.sv
// Averages each run of 2**LOG2_PIX pixels into a zone colour and writes it to
// colour-RAM word BASE_ADDR+zone through a 2-entry queue feeding the write master.
//
//  state   | meaning
//  S_IDLE  | waiting for sop; non-sop beats dropped
//  S_ACCUM | summing pixels of the current zone, pushing finished zones
//  S_DRAIN | last zone queued; waiting for the queue to empty, then frame_done
module mblight_zone_color_writer #(
    parameter int ADDR_W    = 13,
    parameter int BASE_ADDR = 0,
    parameter int NUM_ZONES = 32,
    parameter int LOG2_PIX  = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    mblight_zone_color_writer_if.master   bus,
    output logic                          frame_done,
    output logic                          short_frame
);
    localparam int PIX   = 1 << LOG2_PIX;
    localparam int SUM_W = 8 + LOG2_PIX;
    localparam int CNT_W = (LOG2_PIX > 0) ? LOG2_PIX : 1;
    localparam int ENT_W = ADDR_W + 24;
    localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(PIX - 1);
    localparam logic [7:0]       ZONE_LAST = 8'(NUM_ZONES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [SUM_W-1:0]  sum_r_q, sum_g_q, sum_b_q;
    logic [SUM_W-1:0]  sum_r_d, sum_g_d, sum_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        zone_q, zone_d;
    logic              short_q, short_d;

    logic [ENT_W-1:0]  fifo_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        fifo_cnt_q;

    logic              ready_raw, accept, restart, live, push, pop;
    logic              zone_end, frame_end;
    logic [SUM_W-1:0]  base_r, base_g, base_b;
    logic [SUM_W-1:0]  sum_r_nx, sum_g_nx, sum_b_nx;
    logic [CNT_W-1:0]  base_cnt;
    logic [7:0]        base_zone;
    logic [ENT_W-1:0]  push_data, head;

    // In IDLE a one-pixel zone would push on the sop beat itself, so a full queue must stall it.
    always_comb begin
        ready_raw = 1'b0;
        unique case (state_q)
            S_IDLE:  ready_raw = (LOG2_PIX != 0) || (fifo_cnt_q != 2'd2);
            S_ACCUM: ready_raw = (fifo_cnt_q < 2'd2);
            default: ready_raw = 1'b0;
        endcase
    end

    assign bus.snk_ready = ready_raw & reset_n;
    assign accept  = bus.snk_valid & bus.snk_ready;
    assign restart = accept & bus.snk_sop;
    assign live    = accept & (bus.snk_sop | (state_q == S_ACCUM));

    // A sop beat starts zone 0 afresh, whatever was partially summed before.
    assign base_r    = restart ? '0 : sum_r_q;
    assign base_g    = restart ? '0 : sum_g_q;
    assign base_b    = restart ? '0 : sum_b_q;
    assign base_cnt  = restart ? '0 : cnt_q;
    assign base_zone = restart ? '0 : zone_q;

    assign sum_r_nx = base_r + SUM_W'(bus.snk_data[23:16]);
    assign sum_g_nx = base_g + SUM_W'(bus.snk_data[15:8]);
    assign sum_b_nx = base_b + SUM_W'(bus.snk_data[7:0]);

    assign zone_end  = (base_cnt == PIX_LAST);
    assign frame_end = zone_end && (base_zone == ZONE_LAST);
    assign push      = live & zone_end;
    assign push_data = {sum_r_nx[SUM_W-1:LOG2_PIX], sum_g_nx[SUM_W-1:LOG2_PIX],
                        sum_b_nx[SUM_W-1:LOG2_PIX],
                        ADDR_W'(BASE_ADDR) + ADDR_W'(base_zone)};

    always_comb begin
        state_d    = state_q;
        sum_r_d    = sum_r_q;
        sum_g_d    = sum_g_q;
        sum_b_d    = sum_b_q;
        cnt_d      = cnt_q;
        zone_d     = zone_q;
        short_d    = short_q;
        frame_done = 1'b0;

        if (state_q == S_DRAIN && fifo_cnt_q == 2'd0) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
        end

        if (live) begin
            state_d = S_ACCUM;
            if (restart)
                short_d = 1'b0;
            if (zone_end) begin
                sum_r_d = '0;
                sum_g_d = '0;
                sum_b_d = '0;
                cnt_d   = '0;
                zone_d  = 8'(base_zone + 8'd1);
            end else begin
                sum_r_d = sum_r_nx;
                sum_g_d = sum_g_nx;
                sum_b_d = sum_b_nx;
                cnt_d   = CNT_W'(base_cnt + 1'b1);
                zone_d  = base_zone;
            end
            if (frame_end) begin
                state_d = S_DRAIN;
            end else if (bus.snk_eop) begin
                state_d = S_IDLE;
                short_d = 1'b1;
                sum_r_d = '0;
                sum_g_d = '0;
                sum_b_d = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
            cnt_q   <= '0;
            zone_q  <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_r_q <= sum_r_d;
            sum_g_q <= sum_g_d;
            sum_b_q <= sum_b_d;
            cnt_q   <= cnt_d;
            zone_q  <= zone_d;
            short_q <= short_d;
        end
    end

    assign pop = (fifo_cnt_q != 2'd0) & ~bus.avm_waitrequest;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign head                = fifo_q[rd_ptr_q];
    assign bus.avm_write       = (fifo_cnt_q != 2'd0);
    assign bus.avm_chipselect  = bus.avm_write;
    assign bus.avm_byteenable  = bus.avm_write ? 4'hF : 4'h0;
    assign bus.avm_address     = head[ADDR_W-1:0];
    assign bus.avm_writedata   = {8'h00, head[ENT_W-1:ADDR_W]};
    assign short_frame         = short_q;
endmodule

// File: tb/tb_mblight_zone_color_writer.sv
// Zone colour writer bench: directed frames with random pixels, gaps and stalls,
// checked against a frame-level averaging model.
module tb_mblight_zone_color_writer;
    localparam int ADDR_W = 13;
    localparam int NZ     = 32;
    localparam int L2P    = 6;
    localparam int PIX    = 1 << L2P;
    localparam int FRAME  = NZ * PIX;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_done, short_frame;
    always #5 clk = ~clk;

    mblight_zone_color_writer_if #(.ADDR_W(ADDR_W)) bus ();

    mblight_zone_color_writer #(
        .ADDR_W(ADDR_W), .BASE_ADDR(0), .NUM_ZONES(NZ), .LOG2_PIX(L2P)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .frame_done(frame_done), .short_frame(short_frame)
    );

    int checks = 0;
    int errors = 0;
    longint cyc = 0;
    longint force_until = 0;
    bit wr_rand = 0;
    bit gap_en = 0;

    logic [44:0] got_q[$];
    logic [44:0] exp_q[$];
    int fd_cnt = 0, stab_err = 0, side_err = 0, rdy0_cnt = 0;
    longint last_wr_cyc = 0, fd_gap = 0;
    bit prev_stall = 0;
    logic [44:0] prev_word;

    // reference model state
    bit m_in = 0;
    int m_zone = 0;
    int m_fd = 0;
    bit m_short = 0;
    logic [23:0] m_pix[$];

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_beat(input logic [23:0] px, input bit sop, input bit eop);
        int sr, sg, sb;
        logic [7:0] r8, g8, b8;
        if (sop) begin
            m_in = 1;
            m_zone = 0;
            m_pix.delete();
            m_short = 0;
        end else if (!m_in) begin
            return;
        end
        m_pix.push_back(px);
        if (m_pix.size() == PIX) begin
            sr = 0; sg = 0; sb = 0;
            foreach (m_pix[k]) begin
                sr += int'(m_pix[k][23:16]);
                sg += int'(m_pix[k][15:8]);
                sb += int'(m_pix[k][7:0]);
            end
            r8 = 8'(sr / PIX); g8 = 8'(sg / PIX); b8 = 8'(sb / PIX);
            exp_q.push_back({13'(m_zone), 8'h00, r8, g8, b8});
            m_pix.delete();
            m_zone++;
            if (m_zone == NZ) begin
                m_in = 0;
                m_fd++;
                return;
            end
        end
        if (eop) begin
            m_in = 0;
            m_short = 1;
            m_pix.delete();
        end
    endtask

    task automatic send_beat(input logic [23:0] px, input bit sop, input bit eop);
        int n;
        bit rdy, acc;
        if (gap_en) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.snk_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.snk_data  = px;
        bus.snk_sop   = sop;
        bus.snk_eop   = eop;
        bus.snk_valid = 1'b1;
        n = 0;
        acc = 0;
        while (!acc && n < 4000) begin
            @(negedge clk);
            rdy = bus.snk_ready;
            @(posedge clk); #1;
            acc = rdy;
            n++;
        end
        bus.snk_valid = 1'b0;
        bus.snk_sop   = 1'b0;
        bus.snk_eop   = 1'b0;
        chk("accept_timeout", longint'(acc), 1);
        if (acc) model_beat(px, sop, eop);
    endtask

    task automatic send_frame(input int len, input int eop_at, input bit rnd, input logic [23:0] fixed);
        for (int i = 0; i < len; i++)
            send_beat(rnd ? 24'($urandom) : fixed, i == 0, i == eop_at);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((got_q.size() < exp_q.size() || bus.avm_write) && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_timeout", longint'(n < 6000), 1);
    endtask

    task automatic compare_all(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_write"}, got_q[i], exp_q[i]);
        chk({tag, "_frame_done"}, fd_cnt, m_fd);
        chk({tag, "_short"}, short_frame, m_short);
        chk({tag, "_hold"}, stab_err, 0);
        chk({tag, "_side"}, side_err, 0);
        got_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        m_fd = 0;
    endtask

    initial begin
        bus.avm_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            bus.avm_waitrequest = (cyc < force_until) || (wr_rand && $urandom_range(0, 2) == 0);
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (bus.avm_write && !bus.avm_waitrequest) begin
                got_q.push_back({bus.avm_address, bus.avm_writedata});
                last_wr_cyc = cyc;
            end
            if (prev_stall && (bus.avm_write !== 1'b1 ||
                               {bus.avm_address, bus.avm_writedata} !== prev_word))
                stab_err++;
            if (bus.avm_write && (bus.avm_byteenable !== 4'hF || bus.avm_chipselect !== 1'b1))
                side_err++;
            if (!bus.avm_write && bus.avm_chipselect !== 1'b0)
                side_err++;
            prev_stall = bus.avm_write && bus.avm_waitrequest;
            prev_word  = {bus.avm_address, bus.avm_writedata};
            if (frame_done) begin
                fd_cnt++;
                fd_gap = cyc - last_wr_cyc;
            end
            if (cyc < force_until && bus.snk_valid && !bus.snk_ready)
                rdy0_cnt++;
        end else begin
            prev_stall = 0;
        end
        cyc++;
    end

    initial begin
        logic [44:0] w;
        bus.snk_data  = '0;
        bus.snk_valid = 1'b0;
        bus.snk_sop   = 1'b0;
        bus.snk_eop   = 1'b0;

        // reset state
        #12;
        chk("rst_ready", bus.snk_ready, 0);
        chk("rst_write", bus.avm_write, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_short", short_frame, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", bus.snk_ready, 1);

        // constant-colour frame, no stalls
        send_frame(FRAME, FRAME - 1, 0, 24'h102030);
        wait_idle();
        w = got_q.size() > 31 ? got_q[31] : '0;
        chk("t1_last_word", w, {13'd31, 32'h00102030});
        chk("t1_fd_gap", fd_gap, 1);
        compare_all("t1");

        // truncating average on zone 0
        for (int i = 0; i < FRAME; i++)
            send_beat(i < PIX ? {8'(i), 8'hFF, 8'hFF} : 24'($urandom), i == 0, i == FRAME - 1);
        wait_idle();
        w = got_q.size() > 0 ? got_q[0] : '0;
        chk("t2_zone0", w, {13'd0, 32'h001FFFFF});
        compare_all("t2");

        // long interconnect stall mid-frame
        rdy0_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i == 100) force_until = cyc + 160;
            send_beat(24'($urandom), i == 0, i == FRAME - 1);
        end
        wait_idle();
        chk("t3_ready_low_when_full", longint'(rdy0_cnt > 0), 1);
        compare_all("t3");

        // early eop, then a full frame with random stalls
        send_frame(101, 100, 1, 24'h0);
        wait_idle();
        chk("t4_short_set", short_frame, 1);
        compare_all("t4a");
        wr_rand = 1;
        send_frame(FRAME, FRAME - 1, 1, 24'h0);
        wait_idle();
        compare_all("t4b");

        // restart by sop at pixel 200, with gaps and stalls
        gap_en = 1;
        send_frame(200, -1, 1, 24'h0);
        send_frame(FRAME, FRAME - 1, 1, 24'h0);
        wait_idle();
        compare_all("t5");

        // reset mid-frame with the queue full
        gap_en = 0;
        wr_rand = 0;
        force_until = cyc + 100000;
        send_frame(2 * PIX, -1, 1, 24'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_full_write", bus.avm_write, 1);
        chk("t6_full_ready", bus.snk_ready, 0);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_write", bus.avm_write, 0);
        chk("t6_rst_ready", bus.snk_ready, 0);
        chk("t6_rst_fd", frame_done, 0);
        force_until = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        m_in = 0;
        m_pix.delete();
        m_short = 0;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 70; i++)
            send_beat(24'($urandom), 0, 0);
        wait_idle();
        compare_all("t6_drop");
        send_frame(FRAME, FRAME - 1, 1, 24'h0);
        wait_idle();
        compare_all("t6_frame");

        // random frame lengths, gaps and stalls
        gap_en = 1;
        wr_rand = 1;
        for (int f = 0; f < 3; f++) begin
            int len;
            len = $urandom_range(1, FRAME);
            send_frame(len, len - 1, 1, 24'h0);
            wait_idle();
            compare_all("t7_rand");
        end
        send_frame(FRAME + 40, FRAME + 39, 1, 24'h0);
        wait_idle();
        compare_all("t7_long");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
